dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 84 ++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the CPU has priority, and the external loader/debug port
// takes the slot once it has waited STARVE_LIMIT consecutive cycles. Read data returns 1 cycle later.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        ext_req,
  input  logic [3:0]  ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_pending;
  owner_t     rd_owner;
  logic       cpu_win, ext_win;
  req_t       sel;

  // Grants are gated by rst so nothing reaches memory while in reset.
  always_comb begin
    ext_win   = ext_req && (!cpu_req || (starve_cnt == LIMIT));
    cpu_win   = cpu_req && !ext_win;
    cpu_gnt   = cpu_win && !rst;
    ext_gnt   = ext_win && !rst;
    sel       = '0;
    if (ext_gnt)
      sel = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
    else if (cpu_gnt)
      sel = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    mem_en    = cpu_gnt || ext_gnt;
    mem_we    = sel.we;
    mem_addr  = sel.addr;
    mem_wdata = sel.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_CPU;
    end else begin
      if (!ext_req || ext_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
      rd_pending <= mem_en && (sel.we == 4'b0000);
      if (mem_en && (sel.we == 4'b0000))
        rd_owner <= ext_gnt ? OWN_EXT : OWN_CPU;
    end
  end

  // A reset in the cycle after a granted read drops that read's response.
  assign cpu_rvalid = !rst && rd_pending && (rd_owner == OWN_CPU);
  assign ext_rvalid = !rst && rd_pending && (rd_owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, with every cycle
// compared against a cycle-level reference model and a private copy of the memory.
module tb_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, ext_req;
  logic [3:0]  cpu_we, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Memory device seen by the DUT: 64 words, indexed by addr[7:2].
  logic [31:0] tmem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= tmem[mem_addr[7:2]];
      else tmem[mem_addr[7:2]] <= merge(tmem[mem_addr[7:2]], mem_wdata, mem_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] model_mem [64];
  int          wait_cnt = 0;
  bit          pend_v = 0, pend_ext = 0;
  logic [31:0] pend_data = '0;
  bit          last_cg, last_eg;
  logic        obs_cg, obs_eg;
  logic [31:0] obs_crd, obs_erd;

  task automatic tick();
    bit e_cg, e_eg, e_en, e_crv, e_erv;
    logic [3:0] e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    e_cg = 0; e_eg = 0;
    if (!rst) begin
      e_eg = ext_req && (!cpu_req || wait_cnt >= LIM);
      e_cg = cpu_req && !e_eg;
    end
    e_en = e_cg || e_eg;
    e_we = e_eg ? ext_we : e_cg ? cpu_we : 4'h0;
    e_addr = e_eg ? ext_addr : e_cg ? cpu_addr : 32'h0;
    e_wd = e_eg ? ext_wdata : e_cg ? cpu_wdata : 32'h0;
    e_crv = !rst && pend_v && !pend_ext;
    e_erv = !rst && pend_v && pend_ext;
    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check("ext_gnt", 32'(ext_gnt), 32'(e_eg));
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    check("ext_rvalid", 32'(ext_rvalid), 32'(e_erv));
    check("cpu_rdata", cpu_rdata, e_crv ? pend_data : 32'd0);
    check("ext_rdata", ext_rdata, e_erv ? pend_data : 32'd0);
    obs_cg = cpu_gnt; obs_eg = ext_gnt; obs_crd = cpu_rdata; obs_erd = ext_rdata;
    @(posedge clk);
    if (rst) begin
      wait_cnt = 0; pend_v = 0;
    end else begin
      // Ext waits while denied; once it has waited LIM cycles it keeps that claim until served.
      if (ext_req && !e_eg) wait_cnt = (wait_cnt + 1 > LIM) ? LIM : wait_cnt + 1;
      else wait_cnt = 0;
      pend_v = e_en && (e_we == 4'h0);
      if (pend_v) begin
        pend_ext = e_eg;
        pend_data = model_mem[e_addr[7:2]];
      end
      if (e_en && e_we != 4'h0)
        model_mem[e_addr[7:2]] = merge(model_mem[e_addr[7:2]], e_wd, e_we);
    end
    last_cg = e_cg; last_eg = e_eg;
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  logic [5:0] cseq, eseq;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tmem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      model_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end
    tmem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;

    // Reset with both ports requesting
    rst = 1; idle();
    cpu_req = 1; cpu_addr = 32'h44; ext_req = 1; ext_we = 4'hF; ext_addr = 32'h48; ext_wdata = 32'h1234_5678;
    tick(); tick();
    rst = 0; idle(); tick();

    // CPU read of 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; tick();
    check("rd_gnt", 32'(obs_cg), 32'd1);
    idle(); tick();
    check("rd_data", obs_crd, 32'hDEADBEEF);

    // Starvation: both held continuously for 6 cycles
    cpu_req = 1; cpu_we = 4'hF; cpu_addr = 32'h80; cpu_wdata = 32'h0BAD_F00D;
    ext_req = 1; ext_we = 4'hF; ext_addr = 32'h84; ext_wdata = 32'hCAFE_0001;
    cseq = 0; eseq = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cseq = {cseq[4:0], obs_cg}; eseq = {eseq[4:0], obs_eg};
    end
    check("starve_cpu_seq", 32'(cseq), 32'b111101);
    check("starve_ext_seq", 32'(eseq), 32'b000010);
    idle(); tick();

    // Alternating reads: ext 0x20 then cpu 0x24
    ext_req = 1; ext_addr = 32'h20; tick();
    idle(); cpu_req = 1; cpu_addr = 32'h24; tick();
    check("alt_ext_data", obs_erd, model_mem[8]);
    idle(); tick();
    check("alt_cpu_data", obs_crd, model_mem[9]);

    // Byte write from ext
    ext_req = 1; ext_we = 4'b0100; ext_addr = 32'h30; ext_wdata = 32'h00AB_0000; tick();
    idle(); tick();

    // Reset in the cycle after a granted read
    cpu_req = 1; cpu_addr = 32'h10; tick();
    idle(); rst = 1; tick();
    rst = 0; tick();

    // Random traffic; each requester holds its access until granted
    for (int n = 0; n < 600; n++) begin
      if (!cpu_req || last_cg) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (!ext_req || last_eg) begin
        ext_req = ($urandom_range(0, 1) != 0);
        ext_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        ext_addr = $urandom; ext_wdata = $urandom;
      end
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0; idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
